ro_display_driver: RTL



---
 rtl/ro_display_driver_pkg.sv | 37 +++
 rtl/ro_display_driver_if.sv | 15 +
 rtl/ro_display_driver_bin_to_bcd_serial.sv | 85 ++++++++
 rtl/ro_display_driver.sv | 78 +++++++
 4 files changed

// File: rtl/ro_display_driver_pkg.sv
// Shared types, segment encodings and helpers for the Ro display driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Packed array: index 0 is the rightmost element of the literal.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        if (nibble > 4'd9) return SEG_DASH;
        return SEG_DIGIT[nibble];
    endfunction

    // Decimal digits needed for a BITS-wide unsigned value: ceil(bits*log10(2)).
    function automatic int digits_needed(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/ro_display_driver_if.sv
// Bundle between the execution-stage result bus and the display pins.
// The display driver is the slave; whoever drives Ro is the master.
interface ro_display_if #(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) ();
    logic [BITS-1:0]     Ro;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] bcd_out;
    logic                busy;

    modport master (output Ro, input an, seg, bcd_out, busy);
    modport slave  (input Ro, output an, seg, bcd_out, busy);
endinterface

// File: rtl/ro_display_driver_bin_to_bcd_serial.sv
// Serial double-dabble converter: captures a changed input value and produces
// its packed BCD form BITS+1 cycles later.
module bin_to_bcd_serial
    import display_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     ro,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                busy
);
    localparam int CW = $clog2(BITS + 1);

    conv_state_t         state, state_nx;
    logic [BITS-1:0]     last_val, last_val_nx;
    logic [BITS-1:0]     bin_sr, bin_sr_nx;
    logic [4*DIGITS-1:0] bcd_acc, bcd_acc_nx, bcd_out_nx, adj;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                busy_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_val <= '0;
            bin_sr   <= '0;
            bcd_acc  <= '0;
            cnt      <= '0;
            bcd_out  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            last_val <= last_val_nx;
            bin_sr   <= bin_sr_nx;
            bcd_acc  <= bcd_acc_nx;
            cnt      <= cnt_nx;
            bcd_out  <= bcd_out_nx;
            busy     <= busy_nx;
        end
    end

    always_comb begin
        adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx    = state;
        last_val_nx = last_val;
        bin_sr_nx   = bin_sr;
        bcd_acc_nx  = bcd_acc;
        cnt_nx      = cnt;
        bcd_out_nx  = bcd_out;
        busy_nx     = busy;
        case (state)
            IDLE: begin
                if (ro != last_val) begin
                    bin_sr_nx   = ro;
                    last_val_nx = ro;
                    bcd_acc_nx  = '0;
                    cnt_nx      = CW'(BITS);
                    busy_nx     = 1'b1;
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_acc_nx = {adj[4*DIGITS-2:0], bin_sr[BITS-1]};
                bin_sr_nx  = bin_sr << 1;
                cnt_nx     = cnt - CW'(1);
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                bcd_out_nx = bcd_acc;
                busy_nx    = 1'b0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/ro_display_driver.sv
// Converts the execution-stage result Ro to BCD and scans it onto a
// multiplexed common-anode 7-segment display with optional leading-zero blanking.
module ro_display_driver
    import display_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic clk,
    input  logic rst,
    ro_display_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < digits_needed(BITS)) begin : g_digits_chk
        $error("ro_display_driver: DIGITS too small for BITS");
    end
    if (REFRESH_DIV < 1) begin : g_refresh_chk
        $error("ro_display_driver: REFRESH_DIV must be at least 1");
    end

    logic [4*DIGITS-1:0] bcd_val;
    logic [RW-1:0]       refresh_cnt;
    logic [IW-1:0]       dig_idx;
    logic [4*DIGITS-1:0] upper;
    logic [3:0]          nib;
    logic [6:0]          seg_nx;
    logic [DIGITS-1:0]   an_nx;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;

    bin_to_bcd_serial #(.BITS(BITS), .DIGITS(DIGITS)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .ro      (bus.Ro),
        .bcd_out (bcd_val),
        .busy    (bus.busy)
    );

    assign bus.bcd_out = bcd_val;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            dig_idx     <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            dig_idx     <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + IW'(1);
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // A digit is blank when it and every more-significant nibble are zero.
    always_comb begin
        upper  = bcd_val >> {dig_idx, 2'b00};
        nib    = bcd_val[{dig_idx, 2'b00} +: 4];
        an_nx  = ~(DIGITS'(1) << dig_idx);
        seg_nx = seg_decode(nib);
        if (BLANK_LZ != 0 && dig_idx != '0 && upper == '0) seg_nx = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
        end
    end

endmodule
